// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Shares one line-wide memory port between the instruction
//               cache (port 0) and two data ports (d1, d2). One transaction
//               is granted at a time in round-robin order. The grant is held
//               until memory signals completion. The granted requester then
//               gets a one-cycle ready pulse. A response watchdog aborts a
//               hung transaction, pulses err_pulse with the ready pulse and
//               sets a sticky err flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                         rising-edge clock
//   reset                       synchronous, active-low reset
//   pet_i / addr_i              instruction-cache request (read only)
//   pet_d1/addr_d1/we_d1/wdata_d1  data port 1 request
//   pet_d2/addr_d2/we_d2/wdata_d2  data port 2 request
//   mem_ready                   memory completion pulse
//   mem_pet/mem_addr/mem_we/mem_wdata  latched request to memory
//   rdy_i/rdy_d1/rdy_d2         one-cycle completion pulse to the owner
//   grant                       current owner: 0=i, 1=d1, 2=d2, 3=none
//   err                         sticky timeout flag (cleared by reset only)
//   err_pulse                   one cycle, coincident with an aborted rdy_*
// ============================================================================
module mem_req_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int LINE_W  = 256,
   parameter int TIMEOUT = 64,   // >= 2
   parameter int TO_W    = 7     // 2**TO_W must exceed TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   // instruction cache
   input  logic              pet_i,
   input  logic [ADDR_W-1:0] addr_i,
   // data port 1
   input  logic              pet_d1,
   input  logic [ADDR_W-1:0] addr_d1,
   input  logic              we_d1,
   input  logic [LINE_W-1:0] wdata_d1,
   // data port 2
   input  logic              pet_d2,
   input  logic [ADDR_W-1:0] addr_d2,
   input  logic              we_d2,
   input  logic [LINE_W-1:0] wdata_d2,
   // memory side
   input  logic              mem_ready,
   output logic              mem_pet,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [LINE_W-1:0] mem_wdata,
   // completion pulses
   output logic              rdy_i,
   output logic              rdy_d1,
   output logic              rdy_d2,
   // status
   output logic [1:0]        grant,
   output logic              err,
   output logic              err_pulse
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0]      c_no_owner = 2'd3;
   // Last BUSY count value at which the watchdog fires; the counter starts at
   // 0 on grant, so mem_pet stays high for exactly TIMEOUT cycles.
   localparam logic [TO_W-1:0] c_to_last  = TO_W'(TIMEOUT - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t              state_q,     state_d;
   logic [1:0]          grant_q,     grant_d;
   logic [1:0]          last_q,      last_d;
   logic [TO_W-1:0]     cnt_q,       cnt_d;
   logic                mem_pet_q,   mem_pet_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic                mem_we_q,    mem_we_d;
   logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [2:0]          rdy_q,       rdy_d;
   logic                err_q,       err_d;
   logic                err_pulse_q, err_pulse_d;

   // ------------------------------------------------------------------------
   // Round-robin pick: search starts at the port after the last owner.
   // ------------------------------------------------------------------------
   logic [2:0] req;
   logic       pick_valid;
   logic [1:0] pick_idx;

   assign req = {pet_d2, pet_d1, pet_i};

   always_comb begin
      pick_valid = |req;
      pick_idx   = 2'd0;
      unique case (last_q)
         2'd0: begin
            if      (req[1]) pick_idx = 2'd1;
            else if (req[2]) pick_idx = 2'd2;
            else             pick_idx = 2'd0;
         end
         2'd1: begin
            if      (req[2]) pick_idx = 2'd2;
            else if (req[0]) pick_idx = 2'd0;
            else             pick_idx = 2'd1;
         end
         default: begin
            if      (req[0]) pick_idx = 2'd0;
            else if (req[1]) pick_idx = 2'd1;
            else             pick_idx = 2'd2;
         end
      endcase
   end

   // One-hot ready vector for the current owner.
   logic [2:0] owner_onehot;

   always_comb begin
      owner_onehot = 3'b000;
      unique case (grant_q)
         2'd0:    owner_onehot = 3'b001;
         2'd1:    owner_onehot = 3'b010;
         2'd2:    owner_onehot = 3'b100;
         default: owner_onehot = 3'b000;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      mem_pet_d   = mem_pet_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      rdy_d       = 3'b000;
      err_d       = err_q;
      err_pulse_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               grant_d   = pick_idx;
               last_d    = pick_idx;
               cnt_d     = '0;
               mem_pet_d = 1'b1;
               state_d   = S_BUSY;
               unique case (pick_idx)
                  2'd1: begin
                     mem_addr_d  = addr_d1;
                     mem_we_d    = we_d1;
                     mem_wdata_d = wdata_d1;
                  end
                  2'd2: begin
                     mem_addr_d  = addr_d2;
                     mem_we_d    = we_d2;
                     mem_wdata_d = wdata_d2;
                  end
                  default: begin
                     // Instruction fetches are always reads.
                     mem_addr_d  = addr_i;
                     mem_we_d    = 1'b0;
                     mem_wdata_d = '0;
                  end
               endcase
            end
         end

         S_BUSY: begin
            // Completion wins over a watchdog expiry in the same cycle.
            if (mem_ready) begin
               mem_pet_d = 1'b0;
               rdy_d     = owner_onehot;
               state_d   = S_DONE;
            end else if (cnt_q == c_to_last) begin
               mem_pet_d   = 1'b0;
               rdy_d       = owner_onehot;
               err_d       = 1'b1;
               err_pulse_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DONE: begin
            // rdy_* is visible during this state; release the grant after it.
            grant_d = c_no_owner;
            cnt_d   = '0;
            state_d = S_IDLE;
         end

         default: begin
            state_d   = S_IDLE;
            grant_d   = c_no_owner;
            mem_pet_d = 1'b0;
            cnt_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         grant_q     <= c_no_owner;
         last_q      <= 2'd2;   // port 0 gets first priority
         cnt_q       <= '0;
         mem_pet_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         rdy_q       <= 3'b000;
         err_q       <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         mem_pet_q   <= mem_pet_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         rdy_q       <= rdy_d;
         err_q       <= err_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign mem_pet   = mem_pet_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign rdy_i     = rdy_q[0];
   assign rdy_d1    = rdy_q[1];
   assign rdy_d2    = rdy_q[2];
   assign grant     = grant_q;
   assign err       = err_q;
   assign err_pulse = err_pulse_q;

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single line-wide memory port between three requesters: instruction cache (port 0), data port 1, data port 2.
- Grants one request at a time with round-robin priority and holds the grant until memory signals completion.
- Returns a one-cycle ready pulse to the granted requester.
- Includes a response watchdog that aborts a hung transaction and flags an error.

Parameters:
- ADDR_W, 16, address width on all ports
- LINE_W, 256, memory line width for write data
- TIMEOUT, 64, max cycles to wait for mem_ready before abort (>=2)
- TO_W, 7, counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- pet_i  in  1  instruction-cache request
- addr_i  in  ADDR_W  instruction-cache address (read only)
- pet_d1  in  1  data port 1 request
- addr_d1  in  ADDR_W  data port 1 address
- we_d1  in  1  data port 1 write enable
- wdata_d1  in  LINE_W  data port 1 write line
- pet_d2, addr_d2, we_d2, wdata_d2  as d1, for data port 2
- mem_ready  in  1  memory completion pulse
- mem_pet  out  1  request to memory
- mem_addr  out  ADDR_W  latched address to memory
- mem_we  out  1  latched write enable
- mem_wdata  out  LINE_W  latched write line
- rdy_i, rdy_d1, rdy_d2  out  1 each  one-cycle completion pulse to the granted requester
- grant  out  2  current owner: 0=i, 1=d1, 2=d2, 3=none
- err  out  1  sticky timeout flag
- err_pulse  out  1  one cycle, coincident with the aborted rdy_* pulse

Behaviour:
- Reset (reset==0 at posedge):
  - State IDLE; grant=3.
  - mem_pet, mem_we, all rdy_*, err, err_pulse = 0.
  - mem_addr, mem_wdata = 0.
  - last owner = 2, so port 0 has top priority first.
  - Counter = 0.
  - Reset mid-transaction abandons it silently: no rdy pulse, memory request dropped.
- States: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - If any pet_* is high, pick the first requester in cyclic order starting at (last+1) mod 3.
  - Latch its addr, and its we/wdata. Instruction port forces we=0 and wdata=0.
  - Set grant, set last, assert mem_pet, go to BUSY.
  - With no requests, remain in IDLE.
- BUSY:
  - Hold mem_pet and all latched fields stable; counter increments each cycle.
  - Input changes on any port are ignored.
  - When mem_ready==1: drop mem_pet, pulse rdy_<owner> next cycle, go to DONE.
  - When the counter reaches TIMEOUT-1 without mem_ready: drop mem_pet, pulse rdy_<owner> and err_pulse, set err, go to DONE.
  - If mem_ready arrives in the same cycle as the timeout, it is treated as a normal completion (no err).
- DONE:
  - rdy_* is high this one cycle; grant is still valid.
  - The requester must deassert pet in this cycle.
  - Next state is IDLE with grant=3 and counter=0.
  - A petition still high in the following IDLE cycle is a new request.
- Latency:
  - Request sampled in IDLE at edge N gives mem_pet high from N+1.
  - mem_ready seen at edge M gives rdy high from M+1 to M+2.
  - Minimum turnaround between back-to-back grants is 3 cycles.
- Simultaneous requests: exactly one grant; the others wait.
- Fairness: each waiting port is served within 2 intervening transactions.
- mem_ready in IDLE or DONE: ignored.
- err clears only on reset.

Test Plan:
- Single read: pet_i=1, addr_i=0x0040, mem_ready 3 cycles after mem_pet → mem_addr=0x0040, mem_we=0, grant=0, rdy_i high exactly 1 cycle, rdy_d1/d2 stay 0.
- Write: pet_d2=1, addr_d2=0x0102, we_d2=1, wdata_d2=256'hA5.. → mem_we=1, mem_wdata=256'hA5.. held through BUSY, rdy_d2 pulse.
- Contention: all three pet high continuously after reset, each request dropped on its rdy → grant sequence 0,1,2,0; no port starved.
- Timeout: pet_d1=1, mem_ready never → mem_pet drops after 64 BUSY cycles, then rdy_d1=1 with err_pulse=1, and err stays 1 afterwards.
- Reset mid-BUSY: reset=0 while grant=1 → next cycle mem_pet=0, grant=3, no rdy pulse; after release, pending pet_i is served first.
- Boundary: mem_ready in the same cycle as the timeout → rdy pulse with err=0; stray mem_ready in IDLE → no state change.
